// File: rtl/udp_tx_sched.sv
// Frame scheduler between a packed-frame TX FIFO and a UDP engine.
// It counts queued frames, starts one frame at a time, paces the serializer and enforces an inter-frame gap.
module udp_tx_sched #(
    parameter int LEN     = 113,
    parameter int IFG_CYC = 12,
    parameter int CNT_W   = 4,
    parameter int TO_CYC  = 4096
) (
    input  logic             gmii_clk,
    input  logic             rst_n,
    input  logic             frame_in,
    input  logic             arp_done,
    input  logic             fifo_empty,
    input  logic             udp_tx_data_en,
    input  logic             udp_tx_done,
    output logic             udp_tx_start,
    output logic [15:0]      ip_data_len,
    output logic             fifo_rd_en,
    output logic             ser_load,
    output logic             ser_read,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf_err,
    output logic             len_err,
    output logic             timeout
);
    localparam int               BW       = $clog2(LEN + 1);
    localparam logic [BW-1:0]    LEN_C    = BW'(LEN);
    localparam logic [BW-1:0]    BYTE_ONE = BW'(1);
    localparam logic [15:0]      TO_LAST  = 16'(TO_CYC - 1);
    localparam logic [7:0]       IFG_LAST = 8'(IFG_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        LOAD      = 3'd2,
        WAIT_DATA = 3'd3,
        SEND      = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t           state_q;
    logic [BW-1:0]    byte_cnt_q;
    logic [15:0]      wd_q;
    logic [7:0]       gap_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    logic             start_q;
    logic             rd_q;
    logic             load_q;
    logic             busy_q;
    logic             ovf_q;
    logic             len_err_q;
    logic             timeout_q;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ser_read_s;
    logic             go_s;

    assign ip_data_len = 16'(LEN + 28);

    // Pending-frame bookkeeping: frame_in and a POP in the same cycle cancel out.
    always_comb begin
        pop_s     = (state_q == POP);
        pending_d = pending_q;
        ovf_set_s = 1'b0;
        if (frame_in && !pop_s) begin
            if (pending_q == PEND_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (!frame_in && pop_s) begin
            pending_d = pending_q - PEND_ONE;
        end else begin
            pending_d = pending_q;
        end
    end

    // Byte advance is live during WAIT_DATA too, so the first payload byte is not lost.
    always_comb begin
        ser_read_s = ((state_q == WAIT_DATA) || (state_q == SEND)) &&
                     udp_tx_data_en && (byte_cnt_q < LEN_C);
        go_s       = (pending_q != {CNT_W{1'b0}}) && arp_done && !fifo_empty;
    end

    // Pending counter and overflow flag.
    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end else begin
                ovf_q <= ovf_q;
            end
        end
    end

    // Frame FSM with registered strobes, byte counter, watchdog and gap timer.
    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= {BW{1'b0}};
            wd_q       <= 16'd0;
            gap_q      <= 8'd0;
            start_q    <= 1'b0;
            rd_q       <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            rd_q      <= 1'b0;
            load_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_s) begin
                        state_q <= POP;
                        start_q <= 1'b1;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                    load_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    state_q    <= WAIT_DATA;
                    byte_cnt_q <= {BW{1'b0}};
                    wd_q       <= 16'd0;
                    busy_q     <= 1'b1;
                end
                WAIT_DATA, SEND: begin
                    busy_q <= 1'b1;
                    wd_q   <= wd_q + 16'd1;
                    if (ser_read_s) begin
                        byte_cnt_q <= byte_cnt_q + BYTE_ONE;
                    end
                    if ((state_q == SEND) && udp_tx_data_en && (byte_cnt_q == LEN_C)) begin
                        len_err_q <= 1'b1;
                    end
                    // A done pulse wins over a watchdog expiry in the same cycle.
                    if (udp_tx_done) begin
                        if (byte_cnt_q != LEN_C) begin
                            len_err_q <= 1'b1;
                        end
                        state_q <= GAP;
                        gap_q   <= 8'd0;
                    end else if (wd_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= GAP;
                        gap_q     <= 8'd0;
                    end else if ((state_q == WAIT_DATA) && udp_tx_data_en) begin
                        state_q <= SEND;
                    end
                end
                GAP: begin
                    if (gap_q == IFG_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q   <= gap_q + 8'd1;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign udp_tx_start = start_q;
    assign fifo_rd_en   = rd_q;
    assign ser_load     = load_q;
    assign ser_read     = ser_read_s;
    assign busy         = busy_q;
    assign pending      = pending_q;
    assign ovf_err      = ovf_q;
    assign len_err      = len_err_q;
    assign timeout      = timeout_q;
endmodule
